// File: rtl/norm_unit_pkg.sv
// Shared types and defaults for norm_unit: the 4-bit FSM state encoding and the
// default element width and lane count.
package norm_unit_pkg;

  localparam int unsigned DefDwidth   = 8;
  localparam int unsigned DefNumLanes = 4;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StRun   = 4'd1,
    StDrain = 4'd2,
    StDone  = 4'd3
  } norm_state_e;

endpackage

// File: rtl/norm_unit_lane.sv
// One normalisation lane: subtract mean, then multiply, shift and reduce to DWIDTH.
// Define NORM_SATURATE_EN to clamp the result instead of wrapping it.
module norm_lane #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ld1_i,
  input  logic              ld2_i,
  input  logic              en_i,
  input  logic [DWIDTH-1:0] x_i,
  input  logic [DWIDTH-1:0] mean_i,
  input  logic [DWIDTH-1:0] inv_var_i,
  output logic [DWIDTH-1:0] y_o
);

  localparam int unsigned PW = 2 * DWIDTH + 1;
`ifdef NORM_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic signed [DWIDTH:0]   diff_d, diff_q;
  logic        [DWIDTH-1:0] x_d, x_q, y_d, y_q;
  logic signed [PW-1:0]     diff_ext, inv_ext, prod, shifted;
  logic        [PW-DWIDTH:0] hi;
  logic                     ovf;
  logic        [DWIDTH-1:0] sat_val, reduced;

  always_comb begin
    diff_d   = diff_q;
    x_d      = x_q;
    if (ld1_i) begin
      diff_d = $signed({x_i[DWIDTH-1], x_i}) - $signed({mean_i[DWIDTH-1], mean_i});
      x_d    = x_i;
    end
    diff_ext = {{(PW-DWIDTH-1){diff_q[DWIDTH]}}, diff_q};
    inv_ext  = {{(PW-DWIDTH){inv_var_i[DWIDTH-1]}}, inv_var_i};
    prod     = diff_ext * inv_ext;
    shifted  = prod >>> SHIFT;
    // Result fits in DWIDTH only if all bits from the sign bit of the narrow result up agree
    hi       = shifted[PW-1:DWIDTH-1];
    ovf      = !((&hi) || !(|hi));
    sat_val  = shifted[PW-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    reduced  = (SatEn && ovf) ? sat_val : shifted[DWIDTH-1:0];
    y_d      = y_q;
    if (ld2_i) begin
      y_d = en_i ? reduced : x_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      diff_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      diff_q <= diff_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/norm_unit.sv
// Vector normaliser: run control FSM plus NUM_LANES two-stage norm_lane pipelines.
// Define NORM_SATURATE_EN to saturate lane results instead of wrapping them.
module norm_unit
  import norm_unit_pkg::*;
#(
  parameter int unsigned DWIDTH    = DefDwidth,
  parameter int unsigned NUM_LANES = DefNumLanes,
  parameter int unsigned SHIFT     = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_norm,
  input  logic                        enable_norm,
  input  logic [DWIDTH-1:0]           mean,
  input  logic [DWIDTH-1:0]           inv_var,
  input  logic [CNT_W-1:0]            num_vectors,
  input  logic                        in_data_valid,
  input  logic [NUM_LANES*DWIDTH-1:0] in_data,
  output logic                        out_data_valid,
  output logic [NUM_LANES*DWIDTH-1:0] out_data,
  output logic                        done_norm
);

  norm_state_e       state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q, num_d, num_q;
  logic [DWIDTH-1:0] mean_d, mean_q, inv_d, inv_q;
  logic              en_d, en_q, drain_d, drain_q, done_d, done_q;
  logic              accept, v1_q, v2_q;

  assign accept = (state_q == StRun) && in_data_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    mean_d  = mean_q;
    inv_d   = inv_q;
    en_d    = en_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_norm) begin
          num_d   = num_vectors;
          mean_d  = mean;
          inv_d   = inv_var;
          en_d    = enable_norm;
          cnt_d   = '0;
          state_d = (num_vectors == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (in_data_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == num_q) begin
            state_d = StDrain;
            drain_d = 1'b0;
          end
        end
      end
      StDrain: begin
        // Two drain cycles cover the two pipeline stages behind the last accept
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      mean_q  <= '0;
      inv_q   <= '0;
      en_q    <= 1'b0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      mean_q  <= mean_d;
      inv_q   <= inv_d;
      en_q    <= en_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    norm_lane #(
      .DWIDTH (DWIDTH),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clk_i     (clk),
      .reset_i   (reset),
      .ld1_i     (accept),
      .ld2_i     (v1_q),
      .en_i      (en_q),
      .x_i       (in_data[i*DWIDTH +: DWIDTH]),
      .mean_i    (mean_q),
      .inv_var_i (inv_q),
      .y_o       (out_data[i*DWIDTH +: DWIDTH])
    );
  end

  assign out_data_valid = v2_q;
  assign done_norm      = done_q;

endmodule
